// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store split controller.
// Contents: RISC-V funct3 encodings used by the LSU, the controller state enum,
// and size_of(), which maps a funct3 to its access size in bytes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StSingle,
    StSplit,
    StDone
  } lsu_state_e;

  // Access size in bytes; funct3[2] only selects sign handling.
  function automatic logic [2:0] size_of(input logic [2:0] func3);
    logic [2:0] size;
    case (func3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Final load-data formatting for the LSU response.
// Ports:
//   word_i   assembled word (byte lanes from a split access, or captured Dmem data)
//   func3_i  funct3 of the load
//   split_i  1 = word_i was assembled from byte reads, 0 = single Dmem access
//   rdata_o  extended load data
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  func3_i,
  input  logic        split_i,
  output logic [31:0] rdata_o
);

  // A single access already got its extension from Dmem; only split halfwords
  // need it here. Unused lanes of a split assembly are zero.
  always_comb begin
    rdata_o = word_i;
    if (split_i) begin
      case (func3_i)
        F3_H:    rdata_o = {{16{word_i[15]}}, word_i[15:0]};
        F3_HU:   rdata_o = {16'h0, word_i[15:0]};
        default: rdata_o = word_i;
      endcase
    end
  end

endmodule

// File: rtl/lsu_split_ctrl.sv
// Load/store unit in front of the byte-addressed data memory.
// Aligned accesses go to Dmem as one operation; misaligned halfword/word
// accesses are split into byte operations and loads are reassembled.
// Illegal funct3, out-of-range and (optionally) misaligned accesses return an error.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in idle)
//   req_we/addr/wdata/func3        request fields, latched on acceptance
//   resp_valid/resp_rdata/resp_err one-cycle response pulse
//   dmem_we/a/wd/func3, dmem_rd    Dmem interface (dmem_rd is combinational)
module lsu_split_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_BYTES  = 1024,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_we,
  output logic [31:0] dmem_a,
  output logic [31:0] dmem_wd,
  output logic [2:0]  dmem_func3,
  input  logic [31:0] dmem_rd
);

  lsu_state_e  state_q, state_d;
  logic        we_q, err_q, split_q;
  logic [31:0] addr_q, wdata_q, asm_q;
  logic [2:0]  func3_q;
  logic [1:0]  cnt_q, last_q;

  logic        f3_legal, misaligned, req_err, accept;
  logic [2:0]  req_size;
  logic [32:0] last_byte;
  logic [31:0] ext_rdata;

  // Request classification, evaluated on the live request inputs.
  always_comb begin
    if (req_we) begin
      f3_legal = (req_func3 == F3_B) || (req_func3 == F3_H) || (req_func3 == F3_W);
    end else begin
      f3_legal = (req_func3 == F3_B) || (req_func3 == F3_H) || (req_func3 == F3_W) ||
                 (req_func3 == F3_BU) || (req_func3 == F3_HU);
    end
    req_size   = size_of(req_func3);
    // 33-bit so a wrap past 2^32 shows up in bit 32 instead of aliasing low.
    last_byte  = {1'b0, req_addr} + {30'd0, req_size} - 33'd1;
    misaligned = ((req_size == 3'd2) && req_addr[0]) ||
                 ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
    req_err    = !f3_legal || last_byte[32] || (last_byte >= 33'(DMEM_BYTES)) ||
                 (misaligned && !MISALIGN_EN);
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= F3_W;
      cnt_q   <= '0;
      last_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= req_err;
        split_q <= misaligned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        func3_q <= req_func3;
        cnt_q   <= '0;
        last_q  <= (req_size == 3'd4) ? 2'd3 : 2'd1;
        asm_q   <= '0;
      end else if (state_q == StSingle) begin
        if (!we_q) asm_q <= dmem_rd;
      end else if (state_q == StSplit) begin
        cnt_q <= cnt_q + 2'd1;
        if (!we_q) asm_q[{cnt_q, 3'b000} +: 8] <= dmem_rd[7:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    dmem_we    = 1'b0;
    dmem_a     = '0;
    dmem_wd    = '0;
    dmem_func3 = F3_W;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)         state_d = StDone;
          else if (misaligned) state_d = StSplit;
          else                 state_d = StSingle;
        end
      end
      StSingle: begin
        dmem_we    = we_q;
        dmem_a     = addr_q;
        dmem_wd    = wdata_q;
        dmem_func3 = func3_q;
        state_d    = StDone;
      end
      StSplit: begin
        dmem_we    = we_q;
        dmem_a     = addr_q + {30'd0, cnt_q};
        dmem_wd    = {24'h0, wdata_q[{cnt_q, 3'b000} +: 8]};
        dmem_func3 = we_q ? F3_B : F3_BU;
        if (cnt_q == last_q) state_d = StDone;
      end
      StDone: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset forces the idle output values even before the state register clears.
    if (reset) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      dmem_we    = 1'b0;
      dmem_a     = '0;
      dmem_wd    = '0;
      dmem_func3 = F3_W;
    end
  end

  lsu_load_extend u_load_extend (
    .word_i  (asm_q),
    .func3_i (func3_q),
    .split_i (split_q),
    .rdata_o (ext_rdata)
  );

  assign resp_rdata = (resp_valid && !err_q && !we_q) ? ext_rdata : '0;

endmodule

// File: tb/tb_lsu_split_ctrl.sv
module tb_lsu_split_ctrl;
  import lsu_pkg::*;

  localparam int unsigned MemBytes   = 1024;
  localparam bit          MisalignEn = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        dmem_we;
  logic [31:0] dmem_a, dmem_wd, dmem_rd;
  logic [2:0]  dmem_func3;

  // Second instance with misaligned splitting disabled (loads only).
  logic        v0, rdy0, we0, rv0, re0, d0_we;
  logic [31:0] a0, wd0, rd0, d0_a, d0_wd, d0_rd;
  logic [2:0]  f30, d0_f3;

  logic [7:0] mem     [MemBytes];
  logic [7:0] ref_mem [MemBytes];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          cyc;
    int          nwr;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0, cyc = 0, wr_cnt = 0, d0_wr = 0, last_resp_cyc = -10;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_split_ctrl #(.DMEM_BYTES(MemBytes), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_we(dmem_we), .dmem_a(dmem_a), .dmem_wd(dmem_wd), .dmem_func3(dmem_func3),
    .dmem_rd(dmem_rd)
  );

  lsu_split_ctrl #(.DMEM_BYTES(MemBytes), .MISALIGN_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_addr(a0), .req_wdata(wd0), .req_func3(f30),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(re0),
    .dmem_we(d0_we), .dmem_a(d0_a), .dmem_wd(d0_wd), .dmem_func3(d0_f3),
    .dmem_rd(d0_rd)
  );

  function automatic int f3_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  // Behavioural Dmem: combinational read with RISC-V load extension.
  function automatic logic [31:0] dmem_read(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, idx;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      idx = a + 32'(k);
      if (idx < MemBytes) w[8*k +: 8] = mem[idx[9:0]];
    end
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign dmem_rd = dmem_read(dmem_func3, dmem_a);
  assign d0_rd   = dmem_read(d0_f3, d0_a);

  always @(posedge clk) begin : dmem_write
    logic [31:0] idx;
    if (dmem_we) begin
      for (int k = 0; k < 4; k++) begin
        idx = dmem_a + 32'(k);
        if (k < f3_bytes(dmem_func3) && idx < MemBytes) mem[idx[9:0]] <= dmem_wd[8*k +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected response straight from the access rules.
  task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, output exp_t e);
    bit          legal, mis;
    int          size;
    logic [32:0] last;
    logic [31:0] v, idx;
    e.we = we; e.addr = a; e.f3 = f3; e.err = 1'b0; e.rdata = '0; e.nwr = 0; e.cyc = 0;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = f3_bytes(f3);
    last  = {1'b0, a} + 33'(size - 1);
    mis   = (a % 32'(size)) != 0;
    if (!legal || last >= 33'(MemBytes) || (mis && !MisalignEn)) begin
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      e.lat = mis ? size + 1 : 2;
      v = '0;
      for (int k = 0; k < size; k++) begin
        idx = a + 32'(k);
        if (we) ref_mem[idx[9:0]] = wd[8*k +: 8];
        else    v[8*k +: 8] = ref_mem[idx[9:0]];
      end
      if (we) e.nwr = mis ? size : 1;
      else if (f3 == 3'b000) e.rdata = {{24{v[7]}}, v[7:0]};
      else if (f3 == 3'b001) e.rdata = {{16{v[15]}}, v[15:0]};
      else e.rdata = v;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT responds.
  always @(negedge clk) begin : monitor
    exp_t  e;
    string tag;
    if (reset) begin
      wr_cnt = 0;
    end else begin
      if (dmem_we) wr_cnt++;
      if (d0_we) d0_wr++;
      if (resp_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: got resp_valid=1 err=%b, expected no response", resp_err);
        end else begin
          e   = q.pop_front();
          tag = $sformatf("%s f3=%0d a=%h", e.we ? "ST" : "LD", e.f3, e.addr);
          chk({"resp_err ", tag}, 32'(resp_err), 32'(e.err));
          chk({"resp_rdata ", tag}, resp_rdata, e.rdata);
          chk({"resp_cycle ", tag}, 32'(cyc), 32'(e.cyc));
          chk({"dmem_we_cycles ", tag}, 32'(wr_cnt), 32'(e.nwr));
          wr_cnt = 0;
        end
      end else if (resp_err || resp_rdata != 0) begin
        tests++; fails++;
        $display("FAIL idle_resp: got err=%b rdata=%h, expected 0/0", resp_err, resp_rdata);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input bit push);
    exp_t e;
    bit   ok;
    int   acc;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_func3 = f3;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      if (req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got req_ready=0 for 20 cycles, expected 1");
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    chk("accept_after_done", 32'((acc - 1) > last_resp_cyc), 32'd1);
    if (push) begin
      model(we, a, wd, f3, e);
      e.cyc = acc + e.lat - 1;
      last_resp_cyc = e.cyc;
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge clk);
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  task automatic d0_req(input logic [31:0] a, input logic [2:0] f3, input logic xerr,
                        input logic [31:0] xdata, input int xlat);
    int n;
    bit seen;
    @(negedge clk);
    v0 = 1'b1; a0 = a; f30 = f3;
    #1;
    chk("d0_ready", 32'(rdy0), 32'd1);
    @(posedge clk);
    seen = 1'b0; n = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      v0 = 1'b0;
      n++;
      if (rv0) seen = 1'b1;
    end
    chk($sformatf("d0_latency a=%h", a), 32'(n), 32'(xlat));
    chk($sformatf("d0_err a=%h", a), 32'(re0), 32'(xerr));
    chk($sformatf("d0_rdata a=%h", a), rd0, xdata);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0]  b;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] a;
    int          r, bad;
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = '0;
    req_func3 = F3_W; v0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0; f30 = F3_W;
    for (int i = 0; i < MemBytes; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end

    // Reset holds everything idle even with a valid request present.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_a", dmem_a, 32'd0);
    chk("rst_dmem_wd", dmem_wd, 32'd0);
    chk("rst_dmem_func3", 32'(dmem_func3), 32'(3'b010));
    @(negedge clk);
    #2;
    reset = 1'b0; req_valid = 1'b0;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Directed cases, back-to-back where consecutive.
    issue(1'b1, 32'h10, 32'hDEADBEEF, F3_W, 1'b1);
    issue(1'b0, 32'h10, 32'h0, F3_W, 1'b1);
    issue(1'b1, 32'h21, 32'h11223344, F3_W, 1'b1);
    issue(1'b0, 32'h21, 32'h0, F3_W, 1'b1);
    issue(1'b0, 32'h22, 32'h0, F3_B, 1'b1);
    issue(1'b1, 32'h41, 32'h80, F3_B, 1'b1);
    issue(1'b1, 32'h42, 32'hFF, F3_B, 1'b1);
    issue(1'b0, 32'h41, 32'h0, F3_H, 1'b1);
    issue(1'b0, 32'h41, 32'h0, F3_HU, 1'b1);
    issue(1'b1, 32'h3FE, 32'h12345678, F3_W, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 3'b011, 1'b1);
    issue(1'b1, 32'h10, 32'h0, 3'b100, 1'b1);
    issue(1'b0, 32'hFFFFFFFF, 32'h0, F3_H, 1'b1);
    issue(1'b0, 32'h3FF, 32'h0, F3_BU, 1'b1);
    idle_req();
    drain();

    // Splitting disabled: misaligned is an error, aligned works.
    d0_req(32'h03, F3_H, 1'b1, 32'h0, 1);
    d0_req(32'h11, F3_W, 1'b1, 32'h0, 1);
    d0_req(32'h10, F3_W, 1'b0, 32'hDEADBEEF, 2);

    // Reset during split byte 1 of a misaligned store.
    issue(1'b1, 32'h31, 32'hAABBCCDD, F3_W, 1'b0);
    idle_req();
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_dmem_we", 32'(dmem_we), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_ready_back", 32'(req_ready), 32'd1);
    ref_mem[32'h31] = 8'hDD;
    chk("abort_byte31", 32'(mem[32'h31]), 32'h0000_00DD);
    chk("abort_byte32", 32'(mem[32'h32]), 32'(ref_mem[32'h32]));

    // Random traffic with random gaps.
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        r  = we ? $urandom_range(0, 2) : $urandom_range(0, 4);
        f3 = (r == 3) ? F3_BU : (r == 4) ? F3_HU : 3'(r);
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'($urandom_range(0, 127));
      else if (r < 9) a = 32'($urandom_range(1016, 1023));
      else            a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      issue(we, a, $urandom, f3, 1'b1);
      repeat ($urandom_range(0, 2)) idle_req();
    end
    idle_req();
    drain();

    bad = 0;
    for (int i = 0; i < MemBytes; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (bad == 0) $display("FAIL mem_byte[%0d]: got %h, expected %h", i, mem[i], ref_mem[i]);
        bad++;
      end
    end
    chk("mem_image_bad_bytes", 32'(bad), 32'd0);
    chk("d0_dmem_we_cycles", 32'(d0_wr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_split_ctrl.md
Name: lsu_split_ctrl

Overview:
Load/store unit that sits directly upstream of the byte-addressed data memory (Dmem) in the RISC-V core and drives its we/a/wd/func3 inputs.
- Aligned accesses are forwarded as one Dmem operation.
- Misaligned halfword/word accesses are split into sequential byte operations. Load bytes are reassembled and sign/zero-extended.
- Illegal func3 and out-of-range addresses are rejected with an error response.
- The core stalls on req_ready low.

Parameters:
- DMEM_BYTES, 1024, Dmem size in bytes; valid byte addresses are 0..DMEM_BYTES-1.
- MISALIGN_EN, 1, 1 = split misaligned accesses; 0 = return error for misaligned accesses.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core request strobe
- req_ready  out  1  high only in IDLE and not in reset; request accepted on req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- req_func3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: illegal func3, out of range, or misaligned with MISALIGN_EN=0
- dmem_we  out  1  Dmem write enable
- dmem_a  out  32  Dmem address
- dmem_wd  out  32  Dmem write data
- dmem_func3  out  3  Dmem access size/sign
- dmem_rd  in  32  Dmem combinational read data

Behaviour:
- Clocking/reset:
  - One clock domain; reset is synchronous and active-high.
  - While reset is high: state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, dmem_we=0, dmem_a=0, dmem_wd=0, dmem_func3=3'b010.
- States:
  - IDLE, SINGLE, SPLIT, DONE.
  - All request fields are latched on acceptance; the core may change its inputs afterwards.
- Classification at acceptance, first match wins:
  1. Illegal func3 (load 011/110/111; store 011–111): error.
  2. Range check: the last touched byte address is addr+size-1, computed as a 33-bit sum. Error if it is >= DMEM_BYTES or the sum carries out.
  3. Alignment: misaligned means halfword with a[0]=1, or word with a[1:0]!=0. Misaligned with MISALIGN_EN=0 is an error.
  4. Otherwise aligned → SINGLE; misaligned → SPLIT with N = 2 (halfword) or 4 (word).
- Error path: IDLE → DONE. resp_valid=1 and resp_err=1 in the cycle after acceptance. No Dmem write ever occurs.
- SINGLE (1 cycle):
  - Drives dmem_a=addr, dmem_func3=func3, dmem_wd=wdata, dmem_we=we.
  - Loads capture dmem_rd at the end of the cycle.
  - → DONE. Response appears 2 cycles after acceptance.
- SPLIT (N cycles, byte counter i = 0..N-1):
  - Drives dmem_a=addr+i, dmem_wd={24'h0, wdata[8i+7:8i]}, dmem_we=we.
  - dmem_func3 = 3'b000 for stores, 3'b100 (LBU) for loads.
  - Loads merge dmem_rd[7:0] into assembly byte lane i (little-endian).
  - After i=N-1 → DONE. Response appears N+1 cycles after acceptance.
- DONE (1 cycle):
  - resp_valid=1.
  - resp_rdata: LH sign-extends bit 15; LHU zero-extends; LW passes through; for SINGLE, the captured dmem_rd passes through unchanged.
  - → IDLE. req_ready stays 0 in DONE, so the next acceptance is at the earliest the following cycle.
- Outside issue cycles, dmem_we=0. dmem_we is never high outside SINGLE/SPLIT.
- Reset mid-operation:
  - Abort immediately; no response is generated.
  - Bytes already written in earlier SPLIT cycles remain written.
- Reset and req_valid in the same cycle: reset wins; the request is not accepted.
- Byte counter: 2-bit. No carry between byte lanes. resp_rdata is held at 0 whenever resp_valid=0.

Decomposition:
- Package lsu_pkg:
  - func3 localparams F3_B/H/W/BU/HU.
  - State enum.
  - Function size_of(func3), returning 1, 2 or 4.
- One sub-module: lsu_load_extend. Combinational; takes the assembled word, func3 and the split/single flag, and produces resp_rdata.

Test Plan:
- Aligned SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 → one dmem_we cycle with func3=010; LW response 0xDEADBEEF, resp_err=0, 2 cycles after acceptance.
- Misaligned SW addr=0x21 wdata=0x11223344 → 4 byte writes to 0x21..0x24 with data 44,33,22,11. Then LW 0x21 → 0x11223344 at cycle 5; LB 0x22 → 0x00000033.
- Misaligned LH at 0x41 after SB 0x41=0x80, SB 0x42=0xFF → LH returns 0xFFFFFF80; LHU at 0x41 returns 0x0000FF80; each takes 2 split cycles.
- Errors:
  - SW at 0x3FE → resp_err=1 one cycle after acceptance, dmem_we never high.
  - LW with func3=011 → resp_err=1.
  - MISALIGN_EN=0 with LH 0x03 → resp_err=1.
- Reset asserted during SPLIT cycle i=1 of SW 0x31=0xAABBCCDD → only byte 0x31=DD written; no resp_valid; req_ready returns 1 the cycle after reset deasserts.
- Back-to-back: req_valid held high with two LW requests → second is accepted only after DONE; req_ready=0 throughout SINGLE/DONE.
